// File: rtl/hpi_access_seq_if.sv
// Request/response and HPI software-side signals for the HPI access sequencer.
// master = requester / interface-stage side, slave = the sequencer.
interface hpi_access_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        busy;
    logic [1:0]  sw_address;
    logic [15:0] sw_data_out;
    logic [15:0] sw_data_in;
    logic        sw_r;
    logic        sw_w;
    logic        sw_cs;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, sw_data_in,
        output req_ready, rsp_valid, rsp_rdata, busy,
               sw_address, sw_data_out, sw_r, sw_w, sw_cs
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, sw_data_in,
        input  req_ready, rsp_valid, rsp_rdata, busy,
               sw_address, sw_data_out, sw_r, sw_w, sw_cs
    );
endinterface

// File: rtl/hpi_access_seq.sv
// Sequences one 16-bit HPI access per request: SETUP, STROBE, HOLD, RECOVER,
// driving the interface stage's active-low strobes and capturing read data.
module hpi_access_seq #(
    parameter int unsigned SETUP_CYC   = 1,
    parameter int unsigned STROBE_CYC  = 4,
    parameter int unsigned HOLD_CYC    = 2,
    parameter int unsigned RECOVER_CYC = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    hpi_access_seq_if.slave   bus
);
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        RECOVER
    } state_e;

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                write_q;
    logic                busy_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic [ADDR_W-1:0]   sw_address_q;
    logic [DATA_W-1:0]   sw_data_out_q;
    logic                sw_r_q;
    logic                sw_w_q;
    logic                sw_cs_q;
    logic                cnt_zero;

    assign cnt_zero = (cnt_q == '0);

    // Outputs are set on the edge that enters each phase, so they are
    // registered and already valid during the phase's first cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            write_q       <= 1'b0;
            busy_q        <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            sw_address_q  <= '0;
            sw_data_out_q <= '0;
            sw_r_q        <= 1'b1;
            sw_w_q        <= 1'b1;
            sw_cs_q       <= 1'b1;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        state_q      <= SETUP;
                        cnt_q        <= CNT_W'(SETUP_CYC - 1);
                        write_q      <= bus.req_write;
                        busy_q       <= 1'b1;
                        sw_cs_q      <= 1'b0;
                        sw_address_q <= bus.req_addr;
                        if (bus.req_write) begin
                            sw_data_out_q <= bus.req_wdata;
                        end
                    end
                end
                SETUP: begin
                    if (cnt_zero) begin
                        state_q <= STROBE;
                        cnt_q   <= CNT_W'(STROBE_CYC - 1);
                        sw_w_q  <= ~write_q;
                        sw_r_q  <= write_q;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                STROBE: begin
                    if (cnt_zero) begin
                        state_q <= HOLD;
                        cnt_q   <= CNT_W'(HOLD_CYC - 1);
                        sw_w_q  <= 1'b1;
                        sw_r_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                HOLD: begin
                    // Last HOLD cycle: the interface's registered read data has settled.
                    if (cnt_zero) begin
                        state_q     <= RECOVER;
                        cnt_q       <= CNT_W'(RECOVER_CYC - 1);
                        sw_cs_q     <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= write_q ? '0 : bus.sw_data_in;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                RECOVER: begin
                    if (cnt_zero) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    sw_cs_q <= 1'b1;
                    sw_r_q  <= 1'b1;
                    sw_w_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready   = (state_q == IDLE) && !Reset;
    assign bus.busy        = busy_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.sw_address  = sw_address_q;
    assign bus.sw_data_out = sw_data_out_q;
    assign bus.sw_r        = sw_r_q;
    assign bus.sw_w        = sw_w_q;
    assign bus.sw_cs       = sw_cs_q;
endmodule

// File: tb/tb_hpi_access_seq.sv
// Directed bench for hpi_access_seq: default-timing DUT (a) and a short-timing DUT (b).
module tb_hpi_access_seq;
    logic        Clk = 1'b0;
    logic        Reset;
    logic        sel;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_addr;
    logic [15:0] req_wdata;
    logic [15:0] din;
    logic [15:0] rd_pattern;
    logic [15:0] last_wdata;
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          rsp_cnt = 0;
    int          acc_cnt = 0;
    int          acc_cyc = 0;
    int          prev_acc = 0;

    hpi_access_seq_if bus_a ();
    hpi_access_seq_if bus_b ();

    hpi_access_seq dut_a (.Clk(Clk), .Reset(Reset), .bus(bus_a.slave));
    hpi_access_seq #(.SETUP_CYC(2), .STROBE_CYC(1), .HOLD_CYC(2), .RECOVER_CYC(1))
        dut_b (.Clk(Clk), .Reset(Reset), .bus(bus_b.slave));

    assign bus_a.req_valid  = req_valid && !sel;
    assign bus_b.req_valid  = req_valid && sel;
    assign bus_a.req_write  = req_write;
    assign bus_b.req_write  = req_write;
    assign bus_a.req_addr   = req_addr;
    assign bus_b.req_addr   = req_addr;
    assign bus_a.req_wdata  = req_wdata;
    assign bus_b.req_wdata  = req_wdata;
    assign bus_a.sw_data_in = din;
    assign bus_b.sw_data_in = din;

    logic        v_ready, v_rsp_valid, v_busy, v_r, v_w, v_cs;
    logic [15:0] v_rdata, v_dout;
    logic [1:0]  v_addr;
    assign v_ready     = sel ? bus_b.req_ready   : bus_a.req_ready;
    assign v_rsp_valid = sel ? bus_b.rsp_valid   : bus_a.rsp_valid;
    assign v_busy      = sel ? bus_b.busy        : bus_a.busy;
    assign v_r         = sel ? bus_b.sw_r        : bus_a.sw_r;
    assign v_w         = sel ? bus_b.sw_w        : bus_a.sw_w;
    assign v_cs        = sel ? bus_b.sw_cs       : bus_a.sw_cs;
    assign v_rdata     = sel ? bus_b.rsp_rdata   : bus_a.rsp_rdata;
    assign v_dout      = sel ? bus_b.sw_data_out : bus_a.sw_data_out;
    assign v_addr      = sel ? bus_b.sw_address  : bus_a.sw_address;

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    // Interface model: read data appears one cycle after the read strobe falls.
    always @(posedge Clk) begin
        if (v_cs)      din <= 16'h0000;
        else if (!v_r) din <= rd_pattern;
    end

    always @(negedge Clk) if (v_rsp_valid) rsp_cnt <= rsp_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts at a negedge in IDLE; returns at the negedge of the first IDLE cycle after.
    task automatic do_access(input string name, input logic wr, input logic [1:0] addr,
                             input logic [15:0] wdata, input logic [15:0] exp_rd,
                             input int s, input int t, input int h, input int r,
                             input logic hold, input logic nwr, input logic [1:0] naddr,
                             input logic [15:0] nwdata);
        int  tot;
        logic act;
        tot = s + t + h + r;
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
        check({name, " ready"}, 32'(v_ready), 32'd1);
        prev_acc = acc_cyc;
        acc_cyc  = cyc;
        acc_cnt++;
        if (wr) last_wdata = wdata;
        @(negedge Clk);
        if (hold) begin
            req_write = nwr; req_addr = naddr; req_wdata = nwdata;
        end else begin
            req_valid = 1'b0;
        end
        for (int k = 1; k <= tot; k++) begin
            act = (k > s) && (k <= s + t);
            check($sformatf("%s c%0d cs", name, k), 32'(v_cs), 32'(k > s + t + h));
            check($sformatf("%s c%0d w", name, k), 32'(v_w), 32'(!(wr && act)));
            check($sformatf("%s c%0d r", name, k), 32'(v_r), 32'(!(!wr && act)));
            check($sformatf("%s c%0d rv", name, k), 32'(v_rsp_valid), 32'(k == s + t + h + 1));
            check($sformatf("%s c%0d busy", name, k), 32'(v_busy), 32'd1);
            check($sformatf("%s c%0d rdy", name, k), 32'(v_ready), 32'd0);
            check($sformatf("%s c%0d addr", name, k), 32'(v_addr), 32'(addr));
            check($sformatf("%s c%0d dout", name, k), 32'(v_dout), 32'(last_wdata));
            if (k == s + t + h + 1)
                check($sformatf("%s rdata", name), 32'(v_rdata), 32'(exp_rd));
            @(negedge Clk);
        end
        check({name, " idle busy"}, 32'(v_busy), 32'd0);
        check({name, " idle cs"}, 32'(v_cs), 32'd1);
        check({name, " idle rdy"}, 32'(v_ready), 32'd1);
    endtask

    initial begin
        sel = 1'b0; Reset = 1'b1; last_wdata = 16'h0; rd_pattern = 16'h0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 2'd1; req_wdata = 16'hFFFF;
        @(negedge Clk); @(negedge Clk);
        check("rst cs", 32'(v_cs), 32'd1);
        check("rst r", 32'(v_r), 32'd1);
        check("rst w", 32'(v_w), 32'd1);
        check("rst addr", 32'(v_addr), 32'd0);
        check("rst dout", 32'(v_dout), 32'd0);
        check("rst rv", 32'(v_rsp_valid), 32'd0);
        check("rst rdata", 32'(v_rdata), 32'd0);
        check("rst busy", 32'(v_busy), 32'd0);
        check("rst rdy", 32'(v_ready), 32'd0);
        req_valid = 1'b0; Reset = 1'b0;
        @(negedge Clk);
        check("post rst busy", 32'(v_busy), 32'd0);
        check("post rst rdy", 32'(v_ready), 32'd1);

        // 1: write, 2: read
        do_access("wr1", 1'b1, 2'd2, 16'h1234, 16'h0000, 1, 4, 2, 2, 1'b0, 1'b0, 2'd0, 16'h0);
        rd_pattern = 16'hBEEF;
        do_access("rd2", 1'b0, 2'd0, 16'h0, 16'hBEEF, 1, 4, 2, 2, 1'b0, 1'b0, 2'd0, 16'h0);

        // 3: back-to-back write then read held valid
        rd_pattern = 16'hA5C3;
        do_access("b2b_w", 1'b1, 2'd1, 16'h0001, 16'h0000, 1, 4, 2, 2, 1'b1, 1'b0, 2'd3, 16'h0);
        do_access("b2b_r", 1'b0, 2'd3, 16'h0, 16'hA5C3, 1, 4, 2, 2, 1'b0, 1'b0, 2'd0, 16'h0);
        check("b2b spacing", 32'(acc_cyc - prev_acc), 32'd10);

        // 4: a different request held valid while busy must be ignored
        do_access("busy", 1'b1, 2'd2, 16'h0F0F, 16'h0000, 1, 4, 2, 2, 1'b1, 1'b1, 2'd1, 16'h5555);
        req_valid = 1'b0;
        @(negedge Clk);
        check("busy ignored", 32'(v_busy), 32'd0);
        check("busy rsp count", 32'(rsp_cnt), 32'(acc_cnt));

        // 5: reset during the write strobe
        req_valid = 1'b1; req_write = 1'b1; req_addr = 2'd3; req_wdata = 16'hCAFE;
        @(negedge Clk);
        req_valid = 1'b0;
        @(negedge Clk);
        check("abort w low", 32'(v_w), 32'd0);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        last_wdata = 16'h0;
        check("abort w", 32'(v_w), 32'd1);
        check("abort cs", 32'(v_cs), 32'd1);
        check("abort dout", 32'(v_dout), 32'd0);
        check("abort busy", 32'(v_busy), 32'd0);
        check("abort rv", 32'(v_rsp_valid), 32'd0);
        for (int k = 0; k < 8; k++) @(negedge Clk);
        check("abort rsp count", 32'(rsp_cnt), 32'(acc_cnt));
        rd_pattern = 16'h1357;
        do_access("rd5", 1'b0, 2'd0, 16'h0, 16'h1357, 1, 4, 2, 2, 1'b0, 1'b0, 2'd0, 16'h0);

        // 6: short-timing instance
        sel = 1'b1;
        @(negedge Clk);
        do_access("p_wr", 1'b1, 2'd2, 16'h9876, 16'h0000, 2, 1, 2, 1, 1'b0, 1'b0, 2'd0, 16'h0);
        rd_pattern = 16'h4242;
        do_access("p_rd", 1'b0, 2'd1, 16'h0, 16'h4242, 2, 1, 2, 1, 1'b0, 1'b0, 2'd0, 16'h0);
        @(negedge Clk);
        check("final rsp count", 32'(rsp_cnt), 32'(acc_cnt));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
